// File: rtl/led_pkg.sv
// Shared defaults and types for the LED output stage.
// Also hosts the counter-width helper used by the timebase.
package led_pkg;

    localparam int LED_PWM_BITS  = 8;
    // ~0.66 ms per decay step at 100 MHz
    localparam int LED_DECAY_DIV = 65536;

    typedef logic [LED_PWM_BITS-1:0] led_bright_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Enable-gated prescaler: one-cycle tick every DIV enabled cycles.
// The count holds while en is low and resumes from where it stopped.
module tick_gen
    import led_pkg::*;
#(
    parameter int DIV = LED_DECAY_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int W = cnt_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/led_fader.sv
// Per-LED PWM with snap-on and linear fade-out ("comet tail").
// Brightness changes only at frame boundaries to avoid duty glitches.
module led_fader
    import led_pkg::*;
#(
    parameter int NLEDS      = 8,
    parameter int PWM_BITS   = LED_PWM_BITS,
    parameter int DECAY_DIV  = LED_DECAY_DIV,
    parameter int DECAY_STEP = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NLEDS-1:0] pattern,
    input  logic             enable,
    output logic [NLEDS-1:0] LED,
    output logic             frame_tick
);

    localparam logic [PWM_BITS-1:0] MAX  = '1;
    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [NLEDS-1:0]    led_next;
    logic                decay_tick;
    logic                wrap;

    assign wrap = (pwm_cnt == MAX);

    tick_gen #(
        .DIV (DECAY_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (enable),
        .tick  (decay_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt    <= '0;
            frame_tick <= 1'b0;
            LED        <= '0;
        end else begin
            pwm_cnt    <= pwm_cnt + 1'b1;
            frame_tick <= wrap;
            LED        <= led_next;
        end
    end

    for (genvar g = 0; g < NLEDS; g++) begin : g_ch
        logic [PWM_BITS-1:0] b;
        logic [PWM_BITS-1:0] act;

        // act takes the pre-edge b, so a set in the MAX cycle lands a frame later
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                b   <= '0;
                act <= '0;
            end else begin
                if (pattern[g])
                    b <= MAX;
                else if (decay_tick)
                    b <= (b > STEP) ? b - STEP : '0;
                if (wrap)
                    act <= b;
            end
        end

        assign led_next[g] = (act == MAX) || (pwm_cnt < act);
    end

endmodule

// File: doc/led_fader.md
# led_fader

Downstream output stage for the LED pattern generators. It takes the 8-bit one-hot or pattern word on every clock and drives the physical LED pins through per-LED PWM. A lit pattern bit snaps its LED to full brightness; once the bit drops, that LED fades out linearly, which gives the running-light "comet tail". It sits between the pattern mux and the `LED` pins, in the PLL clock domain.

## Interface
Parameters:
- `NLEDS`, 8: number of LED channels.
- `PWM_BITS`, 8: brightness and PWM counter width. PWM period is 2^PWM_BITS cycles.
- `DECAY_DIV`, 65536: clock cycles per decay step. Legal range is ≥1.
- `DECAY_STEP`, 8: brightness subtracted per decay step. Legal range is 1..2^PWM_BITS-1.

Ports (one clock; reset is asynchronous, active-high):
- `clk`, in, 1: system clock (PLL output).
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `pattern`, in, NLEDS: requested lit LEDs. Sampled every cycle. May be driven combinationally.
- `enable`, in, 1: 1 means decay runs. 0 freezes the prescaler and brightness decay; PWM and pattern loads continue.
- `LED`, out, NLEDS: registered PWM outputs, one per channel.
- `frame_tick`, out, 1: registered one-cycle pulse in the cycle after the PWM counter wraps.

## Operation
- **PWM counter `pwm_cnt`** (PWM_BITS bits):
  - Increments every cycle.
  - Wraps from MAX = 2^PWM_BITS-1 to 0.
- **Prescaler**:
  - Counts 0..DECAY_DIV-1 while `enable`=1 and holds while `enable`=0.
  - `decay_tick` is asserted in the cycle where the count equals DECAY_DIV-1 and `enable`=1. The counter then returns to 0.
  - With DECAY_DIV=1, `decay_tick` equals `enable`.
- **Working brightness `b[i]`**, updated per channel each cycle, in priority order:
  1. `pattern[i]`=1: `b[i]` ← MAX. Set beats decay in the same cycle.
  2. Else if `decay_tick`: `b[i]` ← (`b[i]` > DECAY_STEP) ? `b[i]`-DECAY_STEP : 0. Subtraction saturates at 0 and never wraps.
  3. Else: hold.
- **Active brightness `act[i]`**:
  - Loaded from `b[i]` only on the edge where `pwm_cnt`=MAX (frame boundary); otherwise held.
  - Brightness never changes mid-PWM-period, so there are no duty glitches.
- **Output compare**, registered:
  - `LED[i]` ← 1 if `act[i]`=MAX.
  - Else `LED[i]` ← (`pwm_cnt` < `act[i]`).
  - Result: `act`=0 is always off, `act`=MAX is always on, and otherwise the duty is `act`/2^PWM_BITS.
- **`frame_tick`**: ← (`pwm_cnt`=MAX).

## Timing
- **Reset values** (reset asserted, asynchronous, immediate): `pwm_cnt`, prescaler, all `b`, all `act` = 0; `LED`=0; `frame_tick`=0.
- **Reset mid-fade**: all channels go dark at once. After release, the first active edge gives `pwm_cnt`=1.
- **Pattern-to-LED latency**:
  - `pattern[i]` sampled at edge E gives `b[i]`=MAX after E.
  - `act[i]` loads at the next frame-boundary edge F ≥ E+1.
  - `LED[i]`=1 after edge F+1.
  - Worst case is 2^PWM_BITS+1 cycles.
- **Frame-boundary alignment**: a pattern bit arriving in the `pwm_cnt`=MAX cycle is loaded into `b` on that edge. `act` still receives the old `b` on that edge, so the new value takes effect one frame later.
- **`frame_tick`**: high in the cycle where `pwm_cnt`=0, exactly once per 2^PWM_BITS cycles.
- **`enable` deassert**: freezes the prescaler count. On re-assert, counting resumes from the held value; it does not restart.
- **Full fade duration** from MAX: ceil(MAX/DECAY_STEP) decay ticks.

## Structure
- Shared package (`led_pkg`):
  - `LED_PWM_BITS` default.
  - `LED_DECAY_DIV` default for 100 MHz.
  - `led_bright_t` (PWM_BITS-wide) brightness type.
- Sub-module `tick_gen` (parameter DIV; ports `clk`, `reset`, `en`, `tick`): holds the prescaler. It is reused by other timebase users.
- Per-channel brightness, load and compare logic is a generate loop in `led_fader`, not a separate module.

## Test plan
Bench parameters: NLEDS=8, PWM_BITS=4, DECAY_DIV=4, DECAY_STEP=4, `enable`=1 unless stated.
1. **Reset**: assert `reset` mid-run with `LED`=0xFF → `LED`=0x00 and `frame_tick`=0 immediately, with no clock edge needed. After release, the first `frame_tick` occurs 16 cycles later.
2. **Single pulse and fade**: `pattern`=0x01 for one cycle, then 0x00 → `b[0]` follows 15, 11, 7, 3, 0, one step every 4 cycles. `LED[0]` duty per frame is 16/16, then n/16 for the `act` value latched at each boundary, then 0.
3. **Set beats decay**: hold `pattern`=0x80 across several `decay_tick` cycles → `b[7]` stays 15 and `LED[7]`=1 continuously after the first boundary plus one cycle.
4. **Glitch-free update**: load `b[3]`=15 in mid-frame, at `pwm_cnt`=5 → `LED[3]` is unchanged until `pwm_cnt` wraps, then goes high one cycle later.
5. **Freeze**: `enable`=0 with `b[2]`=7 for 50 cycles → `b[2]` stays 7 and `LED[2]` keeps 7/16 duty. After re-enable, the first decay occurs after the remaining prescaler count.
6. **Saturation**: DECAY_STEP=4 with `b`=3 → next decay gives 0, not 15; `LED` is 0 from the next frame.
